// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates a single RAM port between an icache (single-word
// reads) and a dcache (BLKWORDS-word block transactions). The grant alternates
// when both caches contend, a dcache block is never interrupted, and RAM data
// is forwarded to both caches with no register in the path.
module memory_arbiter #(
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  // Word counter is at least one bit wide so a single-word block still elaborates.
  localparam int CW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
  localparam logic [CW-1:0] WLAST = CW'(BLKWORDS - 1);
  localparam logic [CW-1:0] WZERO = CW'(1'b0);
  localparam logic [CW-1:0] WONE  = CW'(1'b1);

  // RAM handshake encoding; only ACCESS completes a word.
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBLK = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] wcnt_r;
  logic [CW-1:0] next_wcnt_s;
  logic          lastd_r;
  logic          next_lastd_s;

  logic          access_s;
  logic          dreq_s;
  logic          grant_d_s;
  logic          grant_i_s;

  // Word completion and "dcache wants the bus" are used by every process below.
  assign access_s = (ramstate == RAM_ACCESS);
  assign dreq_s   = dREN | dWEN;

  // Loads are a straight wire from RAM; validity is signalled by the waits.
  assign iload = ramload;
  assign dload = ramload;

  // Who owns the RAM port this cycle: held owner in DBLK/IACC, fresh pick in IDLE.
  // The pick is qualified by nRST so nothing is requested while reset is held.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (nRST && dreq_s && !(lastd_r && iREN)) begin
          grant_d_s = 1'b1;
        end else if (nRST && iREN) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b0;
          grant_i_s = 1'b0;
        end
      end
      DBLK: begin
        grant_d_s = 1'b1;
      end
      IACC: begin
        grant_i_s = 1'b1;
      end
      default: begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
      end
    endcase
  end

  // State register: FSM state, block word counter and fairness flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      wcnt_r  <= WZERO;
      lastd_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      wcnt_r  <= next_wcnt_s;
      lastd_r <= next_lastd_s;
    end
  end

  // Next-state logic: start grants, count block words, finish or abort transactions.
  always_comb begin
    next_state_s = state_r;
    next_wcnt_s  = wcnt_r;
    next_lastd_s = lastd_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          next_state_s = DBLK;
          next_wcnt_s  = WZERO;
        end else if (grant_i_s) begin
          next_state_s = IACC;
        end else begin
          next_state_s = IDLE;
        end
      end
      DBLK: begin
        if (access_s) begin
          if (wcnt_r == WLAST) begin
            // Last word of the block: hand priority to the icache next time.
            next_state_s = IDLE;
            next_wcnt_s  = WZERO;
            next_lastd_s = 1'b1;
          end else begin
            next_wcnt_s  = wcnt_r + WONE;
          end
        end else if (!dreq_s) begin
          // dcache withdrew mid-block: give up the rest of the block.
          next_state_s = IDLE;
          next_wcnt_s  = WZERO;
          next_lastd_s = 1'b1;
        end else begin
          next_state_s = DBLK;
        end
      end
      IACC: begin
        if (access_s) begin
          next_state_s = IDLE;
          next_lastd_s = 1'b0;
        end else if (!iREN) begin
          // icache withdrew before completion; fairness history is left as is.
          next_state_s = IDLE;
        end else begin
          next_state_s = IACC;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_wcnt_s  = WZERO;
      end
    endcase
  end

  // Output logic: forward the owner's request to RAM and release its wait on ACCESS.
  always_comb begin
    ramstore = dstore;
    if (grant_i_s) begin
      ramaddr = iaddr;
      ramREN  = 1'b1;
      ramWEN  = 1'b0;
    end else if (grant_d_s) begin
      // A write takes precedence when the dcache raises both strobes.
      ramaddr = daddr;
      ramREN  = dREN & ~dWEN;
      ramWEN  = dWEN;
    end else begin
      ramaddr = daddr;
      ramREN  = 1'b0;
      ramWEN  = 1'b0;
    end
    // IDLE never completes a word, so waits drop only in the owning state.
    if ((state_r == DBLK) && access_s) begin
      dwait = 1'b0;
    end else begin
      dwait = 1'b1;
    end
    if ((state_r == IACC) && access_s) begin
      iwait = 1'b0;
    end else begin
      iwait = 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed per-cycle vectors, a transaction-level
// reference model (owner / words done / who went last), a per-cycle compare
// process, and hand-computed literal checks at key points of each scenario.
module tb_memory_arbiter;

  localparam int BLKWORDS = 2;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0 = nobody, 1 = dcache, 2 = icache.
  int m_owner = 0;
  int m_words = 0;
  bit m_lastd = 1'b0;

  memory_arbiter #(.BLKWORDS(BLKWORDS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Who uses the RAM this cycle: a busy owner keeps it; otherwise alternate fairly.
  function automatic int pick();
    if (m_owner != 0) return m_owner;
    if ((dREN || dWEN) && !(m_lastd && iREN)) return 1;
    if (iREN) return 2;
    return 0;
  endfunction

  // Model update: one word per ACCESS; a block ends after BLKWORDS words or on withdrawal.
  always @(posedge CLK or negedge nRST) begin : model_p
    if (!nRST) begin
      m_owner <= 0;
      m_words <= 0;
      m_lastd <= 1'b0;
    end else begin
      case (m_owner)
        0: begin
          m_owner <= pick();
          m_words <= 0;
        end
        1: begin
          if (ramstate == ACCESS) begin
            if (m_words + 1 == BLKWORDS) begin
              m_owner <= 0;
              m_words <= 0;
              m_lastd <= 1'b1;
            end else begin
              m_words <= m_words + 1;
            end
          end else if (!dREN && !dWEN) begin
            m_owner <= 0;
            m_words <= 0;
            m_lastd <= 1'b1;
          end
        end
        2: begin
          if (ramstate == ACCESS) begin
            m_owner <= 0;
            m_lastd <= 1'b0;
          end else if (!iREN) begin
            m_owner <= 0;
          end
        end
        default: m_owner <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model, mid-cycle.
  always @(negedge CLK) begin : cmp_p
    int who;
    chk32("dload_fwd", dload, ramload);
    chk32("iload_fwd", iload, ramload);
    if (!nRST) begin
      chk1("rst_ramREN", ramREN, 1'b0);
      chk1("rst_ramWEN", ramWEN, 1'b0);
      chk1("rst_iwait", iwait, 1'b1);
      chk1("rst_dwait", dwait, 1'b1);
    end else begin
      who = pick();
      chk1("dwait", dwait, !(m_owner == 1 && ramstate == ACCESS));
      chk1("iwait", iwait, !(m_owner == 2 && ramstate == ACCESS));
      if (who == 1) begin
        chk1("ramREN_d", ramREN, dREN && !dWEN);
        chk1("ramWEN_d", ramWEN, dWEN);
        chk32("ramaddr_d", ramaddr, daddr);
        if (dWEN) chk32("ramstore_d", ramstore, dstore);
      end else if (who == 2) begin
        chk1("ramREN_i", ramREN, 1'b1);
        chk1("ramWEN_i", ramWEN, 1'b0);
        chk32("ramaddr_i", ramaddr, iaddr);
      end else begin
        chk1("ramREN_idle", ramREN, 1'b0);
        chk1("ramWEN_idle", ramWEN, 1'b0);
      end
    end
  end

  // One bus cycle: apply inputs just after the rising edge, return mid-cycle.
  task automatic cyc(input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] ds, input logic ir, input logic [31:0] ia,
                     input logic [1:0] rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    iREN = ir; iaddr = ia; ramstate = rs; ramload = rl;
    @(negedge CLK);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must fall back at once.
  task automatic rst_pulse();
    nRST = 1'b0;
    #1;
    chk1("arst_ramREN", ramREN, 1'b0);
    chk1("arst_ramWEN", ramWEN, 1'b0);
    chk1("arst_dwait", dwait, 1'b1);
    chk1("arst_iwait", iwait, 1'b1);
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramstate = FREE; ramload = 32'h0;
    @(negedge CLK);
    #2;
    chk1("reset_ramREN", ramREN, 1'b0);
    chk1("reset_dwait", dwait, 1'b1);
    @(negedge CLK);
    #2;
    nRST = 1'b1;

    // dcache 2-word read, ACCESS on the second cycle of each word.
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    chk1("a_req", ramREN, 1'b1); chk32("a_addr0", ramaddr, 32'h100); chk1("a_idle_wait", dwait, 1'b1);
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, BUSY, 32'h0);
    chk1("a_busy0", dwait, 1'b1);
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, ACCESS, 32'hA000_0001);
    chk1("a_acc0", dwait, 1'b0); chk32("a_load0", dload, 32'hA000_0001);
    cyc(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0, BUSY, 32'h0);
    chk32("a_addr1", ramaddr, 32'h104); chk1("a_busy1", dwait, 1'b1);
    cyc(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0, ACCESS, 32'hA000_0002);
    chk1("a_acc1", dwait, 1'b0); chk32("a_load1", dload, 32'hA000_0002);
    idle_cyc();
    chk1("a_done", ramREN, 1'b0);

    // iREN and dWEN together from reset: dcache first, then icache.
    rst_pulse();
    cyc(1'b0, 1'b1, 32'h300, 32'h55, 1'b1, 32'h200, FREE, 32'h0);
    chk1("b_wen", ramWEN, 1'b1); chk32("b_addr", ramaddr, 32'h300); chk1("b_iwait", iwait, 1'b1);
    cyc(1'b0, 1'b1, 32'h300, 32'h55, 1'b1, 32'h200, ACCESS, 32'h0);
    chk1("b_dw0", dwait, 1'b0);
    cyc(1'b0, 1'b1, 32'h304, 32'h66, 1'b1, 32'h200, ACCESS, 32'h0);
    chk1("b_dw1", dwait, 1'b0); chk1("b_iwait1", iwait, 1'b1); chk32("b_store1", ramstore, 32'h66);
    cyc(1'b0, 1'b0, 32'h304, 32'h0, 1'b1, 32'h200, FREE, 32'h0);
    chk32("b_iaddr", ramaddr, 32'h200); chk1("b_iren", ramREN, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200, BUSY, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200, ACCESS, 32'hB000_0001);
    chk1("b_iacc", iwait, 1'b0); chk32("b_iload", iload, 32'hB000_0001);
    idle_cyc();

    // Read+write together, icache arriving mid-block stalls.
    cyc(1'b1, 1'b1, 32'h400, 32'h1234, 1'b0, 32'h0, FREE, 32'h0);
    chk1("c_wen", ramWEN, 1'b1); chk1("c_ren", ramREN, 1'b0); chk32("c_store", ramstore, 32'h1234);
    cyc(1'b1, 1'b1, 32'h400, 32'h1234, 1'b0, 32'h0, ACCESS, 32'h0);
    cyc(1'b1, 1'b1, 32'h404, 32'h5678, 1'b1, 32'h500, BUSY, 32'h0);
    chk1("c_istall", iwait, 1'b1); chk32("c_addr_hold", ramaddr, 32'h404);
    cyc(1'b1, 1'b1, 32'h404, 32'h5678, 1'b1, 32'h500, ACCESS, 32'h0);
    chk1("c_istall2", iwait, 1'b1); chk1("c_dw1", dwait, 1'b0); chk32("c_addr_hold2", ramaddr, 32'h404);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h500, FREE, 32'h0);
    chk32("c_iaddr", ramaddr, 32'h500);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h500, ACCESS, 32'hC000_0001);
    chk1("c_iacc", iwait, 1'b0);
    idle_cyc();

    // ERROR three cycles then ACCESS: one word only.
    cyc(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, ERROR, 32'h0);
      chk1("d_err", dwait, 1'b1);
    end
    cyc(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, ACCESS, 32'hD000_0001);
    chk1("d_acc0", dwait, 1'b0);
    cyc(1'b1, 1'b0, 32'h604, 32'h0, 1'b0, 32'h0, BUSY, 32'h0);
    chk1("d_busy1", dwait, 1'b1);
    cyc(1'b1, 1'b0, 32'h604, 32'h0, 1'b0, 32'h0, ACCESS, 32'hD000_0002);
    chk1("d_acc1", dwait, 1'b0);
    cyc(1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 32'h780, FREE, 32'h0);
    chk32("d_ifair", ramaddr, 32'h780);
    cyc(1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 32'h780, ACCESS, 32'hD000_0003);
    chk1("d_iacc", iwait, 1'b0); chk1("d_dstall", dwait, 1'b1);
    idle_cyc();

    // Reset in the middle of a block, then a fresh block from word 0.
    cyc(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    cyc(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0, ACCESS, 32'h0);
    cyc(1'b1, 1'b0, 32'h804, 32'h0, 1'b0, 32'h0, BUSY, 32'h0);
    rst_pulse();
    cyc(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    chk1("e_regrant", ramREN, 1'b1); chk1("e_wait", dwait, 1'b1);
    cyc(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0, ACCESS, 32'hE000_0001);
    chk1("e_acc0", dwait, 1'b0);
    cyc(1'b1, 1'b0, 32'h804, 32'h0, 1'b1, 32'h880, BUSY, 32'h0);
    chk1("e_inblock", iwait, 1'b1); chk32("e_addr", ramaddr, 32'h804);
    cyc(1'b1, 1'b0, 32'h804, 32'h0, 1'b1, 32'h880, ACCESS, 32'hE000_0002);
    chk1("e_acc1", dwait, 1'b0);
    idle_cyc();

    // Block abort, then icache withdrawal before ACCESS.
    cyc(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    cyc(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 32'h0, ACCESS, 32'h0);
    cyc(1'b0, 1'b0, 32'h904, 32'h0, 1'b0, 32'h0, FREE, 32'h0);
    chk1("f_abort_ren", ramREN, 1'b0); chk1("f_abort_wen", ramWEN, 1'b0);
    cyc(1'b1, 1'b0, 32'hA00, 32'h0, 1'b1, 32'h980, FREE, 32'h0);
    chk32("f_ifair", ramaddr, 32'h980);
    cyc(1'b1, 1'b0, 32'hA00, 32'h0, 1'b1, 32'h980, ACCESS, 32'hF000_0001);
    chk1("f_iacc", iwait, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h990, FREE, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h990, BUSY, 32'h0);
    cyc(1'b1, 1'b0, 32'hB00, 32'h0, 1'b1, 32'h9A0, FREE, 32'h0);
    chk32("f_dfair", ramaddr, 32'hB00);
    idle_cyc();
    idle_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter BLKWORDS, default 2, meaning the number of data words per dcache block transaction.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports iREN  input  1 / iaddr  input  32: icache word read request and address.
REQ-005 SHALL have ports iwait  output  1 / iload  output  32: icache stall and returned word.
REQ-006 SHALL have ports dREN  input  1 / dWEN  input  1 / daddr  input  32 / dstore  input  32: dcache read request, write request, word address and write data.
REQ-007 SHALL have ports dwait  output  1 / dload  output  32: dcache stall and returned word.
REQ-008 SHALL have ports ramREN  output  1 / ramWEN  output  1 / ramaddr  output  32 / ramstore  output  32: RAM request side.
REQ-009 SHALL have ports ramload  input  32 / ramstate  input  2: RAM data, state FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-010 SHALL implement states IDLE, DBLK, IACC, plus a word counter wcnt (width clog2(BLKWORDS)) and a 1-bit flag lastd (last completed grant was dcache).
REQ-011 SHALL in IDLE drive ramREN=ramWEN=0, iwait=dwait=1, and select the next grant combinationally, driving the granted request to RAM in the same cycle.
REQ-012 SHALL grant dcache when (dREN|dWEN) and not (lastd and iREN); otherwise grant icache when iREN; otherwise stay IDLE.
REQ-013 SHALL on a dcache grant enter DBLK with wcnt=0; on an icache grant enter IACC.
REQ-014 SHALL while dcache is granted forward ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-015 SHALL while icache is granted forward ramaddr=iaddr, ramREN=1, ramWEN=0; ramstore don't-care.
REQ-016 SHALL drive dload=ramload and iload=ramload at all times; values are meaningful only when the matching wait is 0.
REQ-017 SHALL drive dwait=0 only when dcache is granted and ramstate==ACCESS; iwait=0 only when icache is granted and ramstate==ACCESS; both 1 otherwise.
REQ-018 SHALL treat ramstate BUSY, FREE and ERROR as not-complete: wait held at 1, request held, no state change.
REQ-019 SHALL in DBLK, on each ACCESS, increment wcnt; when wcnt==BLKWORDS-1 at ACCESS, set lastd=1 and return to IDLE.
REQ-020 SHALL hold the dcache grant across the whole block; icache requests arriving mid-block stall (iwait=1) until the block ends.
REQ-021 SHALL abort DBLK to IDLE (wcnt cleared, lastd=1) if dREN and dWEN are both 0 for a cycle with no ACCESS; no RAM request is issued in that cycle.
REQ-022 SHALL in IACC, on ACCESS, set lastd=0 and return to IDLE; if iREN drops before ACCESS, return to IDLE with lastd unchanged.
REQ-023 SHALL complete exactly one word per ACCESS cycle; back-to-back ACCESS cycles in DBLK complete consecutive words with no bubble.
REQ-024 SHALL register nothing on the RAM data path (zero-cycle forward of ramload to loads).

Reset
REQ-025 SHALL on nRST=0 asynchronously set state=IDLE, wcnt=0, lastd=0; outputs then read ramREN=0, ramWEN=0, iwait=1, dwait=1.
REQ-026 SHALL on reset mid-block abandon the transaction; first cycle after release behaves as IDLE with no pending grant history.

Verification
REQ-027 SHALL cover: dREN=1 daddr=0x100, RAM returns ACCESS on 2nd cycle each word, dcache steps addr 0x100->0x104 -> two dwait=0 pulses, dload=RAM data, then IDLE.
REQ-028 SHALL cover: iREN=1 and dWEN=1 together from reset -> dcache granted first (ramWEN=1, ramaddr=daddr); after 2 words icache granted, iwait=0 on its ACCESS.
REQ-029 SHALL cover: iREN asserted during dcache word 1 of 2 -> iwait stays 1 until DBLK exits; no ramaddr change mid-block.
REQ-030 SHALL cover: dREN=1 dWEN=1 simultaneously -> ramWEN=1, ramREN=0, ramstore=dstore.
REQ-031 SHALL cover: ramstate=ERROR for 3 cycles then ACCESS -> dwait=1 for 3 cycles, 0 on the 4th, wcnt advances once.
REQ-032 SHALL cover: nRST pulsed while in DBLK wcnt=1 -> state IDLE, dwait=1, ramREN=ramWEN=0 immediately; next request restarts at wcnt=0.
